q2_io: RTL and testbench

Memory-mapped I/O responder for the q2 CPU bus at address 0xFFF. It is the device end of the console port that the CPU drives through `wrm`/`rdm`. Writes are decoded into character-display data or commands and stored in a 128-byte character buffer. Reads return the debounced keypad state, active-low, plus a busy flag. A display scanner reads the buffer through a separate synchronous port.

---
 rtl/q2_io_pkg.sv | 22 ++
 rtl/q2_io_debounce.sv | 53 +++++
 rtl/q2_io.sv | 114 +++++++++++
 tb/tb_q2_io.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q2_io_pkg.sv
// rtl/q2_io_pkg.sv - shared constants, clear-state enum and character filter for q2_io
package q2_io_pkg;

  localparam logic [11:0] IO_ADDR_DEFAULT = 12'hFFF;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_BAD   = 8'h3F;
  localparam logic [7:0] CHAR_MIN   = 8'h20;
  localparam logic [7:0] CHAR_MAX   = 8'h7E;

  localparam int CMD_BIT     = 8;
  localparam int SETADDR_BIT = 7;
  localparam int CLEAR_BIT   = 0;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  // Non-printable bytes show up as '?' on the display.
  function automatic logic [7:0] filter_char(input logic [7:0] c);
    return ((c < CHAR_MIN) || (c > CHAR_MAX)) ? CHAR_BAD : c;
  endfunction

endpackage

// File: rtl/q2_io_debounce.sv
// rtl/q2_io_debounce.sv - keypad 2-FF synchronizer plus optional debounce filter (Q2_IO_DEBOUNCE_EN)
module q2_io_debounce #(
  parameter int DB_SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] key_n,
  output logic [10:0] key_db
);

  logic [10:0] sync1;
  logic [10:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef Q2_IO_DEBOUNCE_EN
  logic [DB_SHIFT-1:0] tick_cnt;
  logic [10:0]         samp;
  logic [10:0]         agree;
  logic                tick;

  assign tick  = &tick_cnt;
  // A bit moves only when this tick's sample matches the previous tick's.
  assign agree = ~(samp ^ ~sync2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      samp     <= '0;
      key_db   <= '0;
    end else begin
      tick_cnt <= tick_cnt + DB_SHIFT'(1);
      if (tick) begin
        samp   <= ~sync2;
        key_db <= (agree & ~sync2) | (~agree & key_db);
      end
    end
  end
`else
  logic unused_db_shift;
  assign unused_db_shift = (DB_SHIFT > 0);
  assign key_db          = ~sync2;
`endif

endmodule

// File: rtl/q2_io.sv
// rtl/q2_io.sv - q2 console I/O responder: 128-byte char buffer, clear FSM, keypad read port.
// Keypad debounce is compiled in with Q2_IO_DEBOUNCE_EN.
module q2_io
  import q2_io_pkg::*;
#(
  parameter logic [11:0] IO_ADDR  = IO_ADDR_DEFAULT,
  parameter int          DB_SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        wrm,
  input  logic        rdm,
  input  logic [10:0] key_n,
  input  logic [6:0]  disp_raddr,
  output logic [7:0]  disp_rdata,
  output logic        busy
);

  clr_state_e  state;
  logic [6:0]  addr;
  logic [6:0]  cnt;
  logic        boot;
  logic        wrm_q;
  logic [7:0]  buf_mem [128];
  logic [10:0] key_db;

  logic        wr_hit;
  logic        rd_hit;
  logic        set_cmd;
  logic        clr_cmd;
  logic        data_cmd;
  logic        buf_we;
  logic [6:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic        unused_hi;

  assign wr_hit    = wrm & ~wrm_q & (abus == IO_ADDR);
  assign rd_hit    = rdm & (abus == IO_ADDR);
  assign set_cmd   = wr_hit & dbus[CMD_BIT] & dbus[SETADDR_BIT];
  assign clr_cmd   = wr_hit & dbus[CMD_BIT] & ~dbus[SETADDR_BIT] & dbus[CLEAR_BIT];
  assign data_cmd  = wr_hit & ~dbus[CMD_BIT];
  assign unused_hi = ^dbus[11:9];

  assign dbus = rd_hit ? {~busy, ~key_db} : 12'bz;

  q2_io_debounce #(
    .DB_SHIFT(DB_SHIFT)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_n),
    .key_db (key_db)
  );

  // The clear sweep owns the write port; bus data only lands while idle.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = addr;
    buf_wdata = filter_char(dbus[7:0]);
    if (state == CLEAR) begin
      buf_we    = 1'b1;
      buf_waddr = cnt;
      buf_wdata = CHAR_SPACE;
    end else if (!boot && data_cmd) begin
      buf_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[buf_waddr] <= buf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      addr       <= '0;
      boot       <= 1'b1;
      wrm_q      <= 1'b0;
      disp_rdata <= '0;
    end else begin
      wrm_q      <= wrm;
      disp_rdata <= buf_mem[disp_raddr];
      case (state)
        IDLE: begin
          if (boot || clr_cmd) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
            addr  <= '0;
            boot  <= 1'b0;
          end else if (set_cmd) begin
            addr <= dbus[6:0];
          end else if (data_cmd) begin
            addr <= addr + 7'd1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q2_io.sv
// tb/tb_q2_io.sv - self-checking bench for q2_io; keypad expectations follow Q2_IO_DEBOUNCE_EN
module tb_q2_io;

  localparam int          DB_SHIFT = 4;
  localparam logic [11:0] IO       = 12'hFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrm = 1'b0;
  logic        rdm = 1'b0;
  logic [11:0] abus = 12'hFFF;
  logic [11:0] tb_dbus = '0;
  logic        tb_drv = 1'b0;
  logic [10:0] key_n = '1;
  logic [6:0]  disp_raddr = '0;
  logic [7:0]  disp_rdata;
  logic        busy;
  wire  [11:0] dbus;

  assign dbus = tb_drv ? tb_dbus : 12'bz;

  q2_io #(
    .IO_ADDR  (IO),
    .DB_SHIFT (DB_SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .abus       (abus),
    .dbus       (dbus),
    .wrm        (wrm),
    .rdm        (rdm),
    .key_n      (key_n),
    .disp_raddr (disp_raddr),
    .disp_rdata (disp_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: buffer contents, write pointer, cycles of busy left.
  logic [7:0] m_mem [128];
  int         m_addr = 0;
  int         m_busy = 0;

  typedef struct {
    logic [11:0] w;
    logic [7:0]  exp;
  } filt_vec_t;

  typedef struct {
    logic [11:0] a;
    logic        rd;
    logic        drv;
    logic [11:0] exp;
  } rd_vec_t;

  filt_vec_t fv [10];
  rd_vec_t   rv [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void model_apply(input logic [11:0] w);
    if (w[8]) begin
      if (w[7]) m_addr = int'(w[6:0]);
      else if (w[0]) begin
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_addr = 0;
        m_busy = 128;
      end
    end else begin
      m_mem[m_addr] = (w[7:0] < 8'h20 || w[7:0] > 8'h7E) ? 8'h3F : w[7:0];
      m_addr = (m_addr + 1) % 128;
    end
  endfunction

  function automatic logic [11:0] rand_word();
    logic [11:0] w;
    int k;
    w = 12'($urandom);
    k = $urandom_range(0, 39);
    if (k == 0) begin w[8] = 1'b1; w[7] = 1'b0; w[0] = 1'b1; end
    else if (k == 1) begin w[8] = 1'b1; w[7] = 1'b0; w[0] = 1'b0; end
    else if (k <= 5) begin w[8] = 1'b1; w[7] = 1'b1; end
    else w[8] = 1'b0;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_busy > 0) m_busy--;
  endtask

  task automatic bus_write(input logic [11:0] w, input logic [11:0] a = 12'hFFF);
    logic hit;
    abus = a; tb_dbus = w; tb_drv = 1'b1; wrm = 1'b1;
    hit = (a == IO) && (m_busy == 0);
    tick();
    wrm = 1'b0; tb_drv = 1'b0; abus = IO;
    if (hit) model_apply(w);
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [11:0] v);
    abus = a; rdm = 1'b1;
    @(negedge clk);
    v = dbus;
    tick();
    rdm = 1'b0;
  endtask

  task automatic scan(input int a, output logic [7:0] d);
    disp_raddr = 7'(a);
    tick();
    d = disp_rdata;
  endtask

  task automatic scan_all_space(input string name);
    logic [7:0] d;
    for (int a = 0; a < 128; a++) begin
      scan(a, d);
      check({name, " space"}, d, 8'h20);
    end
  endtask

  task automatic boot_clear(input string name);
    int n;
    rst = 1'b1; abus = IO; rdm = 1'b1;
    @(negedge clk);
    check({name, " pre"}, dbus, 12'hFFF);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      @(negedge clk);
      if (dbus === 12'h7FF) n++;
      else break;
    end
    check({name, " busy cycles"}, n, 128);
    check({name, " after"}, dbus, 12'hFFF);
    tick();
    rdm = 1'b0;
  endtask

  task automatic run_clear(input logic [11:0] w2, input int when, output int n);
    bus_write(12'h101);
    n = 0;
    for (int c = 1; c < 300; c++) begin
      if (c == when) begin
        abus = IO; tb_dbus = w2; tb_drv = 1'b1; wrm = 1'b1;
      end
      @(negedge clk);
      if (busy) n++;
      else if (c >= when) break;
      @(posedge clk);
      #1;
      wrm = 1'b0; tb_drv = 1'b0;
    end
    @(posedge clk);
    #1;
    wrm = 1'b0; tb_drv = 1'b0;
    tick();
  endtask

  task automatic key_test();
    logic [11:0] v [80];
    logic [10:0] hist [80];
    logic [11:0] e;
    int first;
    int bad;
    abus = IO; rdm = 1'b1;
    for (int t = 0; t < 80; t++) begin
      key_n[2] = (t < 12) ? (((t % 4) < 2) ? 1'b0 : 1'b1) : 1'b0;
      hist[t] = key_n;
      @(negedge clk);
      v[t] = dbus;
      tick();
    end
`ifdef Q2_IO_DEBOUNCE_EN
    first = -1;
    bad = 0;
    for (int t = 0; t < 14; t++) check("bounce ignored", v[t], 12'hFFF);
    for (int t = 0; t < 80; t++) if (first < 0 && v[t] === 12'hFFB) first = t;
    check_range("press latency", first, 14, 47);
    if (first >= 0) for (int t = first; t < 80; t++) if (v[t] !== 12'hFFB) bad++;
    check("press stable", bad, 0);
`else
    for (int t = 0; t < 80; t++) begin
      e = 12'hFFF;
      if (t >= 2) e = {1'b1, hist[t-2]};
      check("key passthru", v[t], e);
    end
`endif
    key_n[2] = 1'b1;
    first = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (first < 0 && dbus === 12'hFFF) first = t;
      tick();
    end
`ifdef Q2_IO_DEBOUNCE_EN
    check_range("release latency", first, 19, 34);
`else
    check("release latency", first, 2);
`endif
    rdm = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic [11:0] v;
    logic [11:0] w;
    logic [11:0] a;
    logic [11:0] e;
    int n;
    int op;
    int ra;
    int b;

    fv[0] = '{w: 12'h007, exp: 8'h3F};
    fv[1] = '{w: 12'h07F, exp: 8'h3F};
    fv[2] = '{w: 12'h07E, exp: 8'h7E};
    fv[3] = '{w: 12'h01F, exp: 8'h3F};
    fv[4] = '{w: 12'h020, exp: 8'h20};
    fv[5] = '{w: 12'h021, exp: 8'h21};
    fv[6] = '{w: 12'h0FF, exp: 8'h3F};
    fv[7] = '{w: 12'h080, exp: 8'h3F};
    fv[8] = '{w: 12'h041, exp: 8'h41};
    fv[9] = '{w: 12'hE5A, exp: 8'h5A};

    rv[0] = '{a: 12'hFFF, rd: 1'b1, drv: 1'b0, exp: 12'hFFF};
    rv[1] = '{a: 12'hFFE, rd: 1'b1, drv: 1'b1, exp: 12'h2A5};
    rv[2] = '{a: 12'hFFF, rd: 1'b0, drv: 1'b1, exp: 12'h2A5};
    rv[3] = '{a: 12'h7FF, rd: 1'b1, drv: 1'b1, exp: 12'h2A5};
    rv[4] = '{a: 12'h000, rd: 1'b0, drv: 1'b1, exp: 12'h2A5};

    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset disp_rdata", disp_rdata, 8'h00);
    rdm = 1'b1;
    @(negedge clk);
    check("reset read", dbus, 12'hFFF);
    tick();
    rdm = 1'b0;

    boot_clear("boot");
    scan_all_space("boot");

    foreach (rv[i]) begin
      abus = rv[i].a; rdm = rv[i].rd; tb_drv = rv[i].drv; tb_dbus = 12'h2A5;
      @(negedge clk);
      check("read decode", dbus, rv[i].exp);
      tick();
    end
    rdm = 1'b0; tb_drv = 1'b0; abus = IO;

    bus_write(12'h1C5); tick();
    bus_write(12'h041); tick();
    bus_write(12'h042); tick();
    bus_write(12'h043); tick();
    scan(69, d); check("buf69", d, 8'h41);
    scan(70, d); check("buf70", d, 8'h42);
    scan(71, d); check("addr71", d, 8'h43);

    bus_write(12'h1FF); tick();
    bus_write(12'h043); tick();
    bus_write(12'h044); tick();
    scan(127, d); check("buf127", d, 8'h43);
    scan(0, d);   check("wrap buf0", d, 8'h44);

    bus_write(12'h1B0); tick();
    foreach (fv[i]) begin
      bus_write(fv[i].w);
      tick();
    end
    foreach (fv[i]) begin
      scan(48 + i, d);
      check("filter", d, fv[i].exp);
    end

    bus_write(12'h194); tick();
    abus = IO; tb_dbus = 12'h047; tb_drv = 1'b1; wrm = 1'b1;
    repeat (3) tick();
    wrm = 1'b0; tb_drv = 1'b0;
    tick();
    bus_write(12'h048); tick();
    scan(20, d); check("held strobe", d, 8'h47);
    scan(21, d); check("held strobe next", d, 8'h48);

    run_clear(12'h041, 2, n);
    check("clear busy len", n, 128);
    scan_all_space("clear");
    bus_write(12'h045); tick();
    scan(0, d); check("clear addr0", d, 8'h45);
    scan(1, d); check("clear addr1", d, 8'h20);

    run_clear(12'h101, 50, n);
    check("second clear ignored", n, 128);

    run_clear(12'h18A, 129, n);
    check("clear busy len end", n, 128);
    bus_write(12'h046); tick();
    scan(10, d); check("setaddr at clear end", d, 8'h46);
    scan(0, d);  check("setaddr end buf0", d, 8'h20);

    bus_write(12'h101);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check("reset abort busy", busy, 1'b0);
    tick();
    tick();
    boot_clear("reset abort");
    scan_all_space("reset abort");

    key_test();

    m_busy = 0;
    bus_write(12'h101);
    tick();
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        w = rand_word();
        a = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 4094)) : IO;
        bus_write(w, a);
        tick();
      end else if (op <= 8) begin
        ra = $urandom_range(0, 127);
        b = m_busy;
        scan(ra, d);
        if (b == 0) check("rand scan", d, m_mem[ra]);
      end else begin
        e = {(m_busy == 0), 11'h7FF};
        bus_read(IO, v);
        check("rand read", v, e);
      end
    end
    for (int k = 0; k < 200 && m_busy > 0; k++) tick();
    for (int i = 0; i < 128; i++) begin
      scan(i, d);
      check("final scan", d, m_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
